// File: rtl/ir_decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, the MIPS32 decode stage and
// the operand/extension logic downstream of it.
interface ir_decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [5:0]  Op;
    logic [5:0]  Func;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [15:0] Imm16;
    logic [4:0]  Shamt;
    logic        Se;
    logic        ImmSel;
    logic        ShiftSel;
    logic        Illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_inst, out_pc,
               Op, Func, Rs, Rt, Rd, Imm16, Shamt,
               Se, ImmSel, ShiftSel, Illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_inst, out_pc,
               Op, Func, Rs, Rt, Rd, Imm16, Shamt,
               Se, ImmSel, ShiftSel, Illegal
    );
endinterface

// File: rtl/ir_decode_stage.sv
// One-entry instruction register with MIPS32 field decode; control flags are
// decoded from the incoming word and registered alongside it.
module ir_decode_stage (
    input  logic               Clk,
    input  logic               Rst,
    ir_decode_stage_if.slave   bus
);

    typedef struct packed {
        logic se;
        logic imm_sel;
        logic shift_sel;
        logic illegal;
    } dec_flags_t;

    logic        valid_q;
    logic [31:0] inst_q;
    logic [31:0] pc_q;
    dec_flags_t  flags_q;
    dec_flags_t  flags_d;
    logic        transfer;

    logic [5:0] in_op;
    logic [5:0] in_func;

    assign in_op   = bus.in_inst[31:26];
    assign in_func = bus.in_inst[5:0];

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is inferred.
    always_comb begin
        flags_d = '0;
        unique case (in_op)
            6'b000000: begin
                flags_d.shift_sel = in_func inside {6'b000000, 6'b000010, 6'b000011};
                flags_d.illegal   = !(in_func inside {
                    6'b000000, 6'b000010, 6'b000011, 6'b001000,
                    6'b100000, 6'b100001, 6'b100010, 6'b100011,
                    6'b100100, 6'b100101, 6'b100110, 6'b100111,
                    6'b101010, 6'b101011});
            end
            6'b000010, 6'b000011: ;
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b100011, 6'b101011: begin
                flags_d.se      = 1'b1;
                flags_d.imm_sel = 1'b1;
            end
            6'b000100, 6'b000101: flags_d.se = 1'b1;
            6'b001100, 6'b001101, 6'b001110, 6'b001111: flags_d.imm_sel = 1'b1;
            default: flags_d.illegal = 1'b1;
        endcase
    end

    assign bus.in_ready = !valid_q || bus.out_ready || bus.flush;
    assign transfer     = bus.in_valid && bus.in_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
            flags_q <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (transfer) begin
            valid_q <= 1'b1;
            inst_q  <= bus.in_inst;
            pc_q    <= bus.in_pc;
            flags_q <= flags_d;
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Field outputs are slices of the instruction flop, so they are registered too.
    assign bus.out_valid = valid_q;
    assign bus.out_inst  = inst_q;
    assign bus.out_pc    = pc_q;
    assign bus.Op        = inst_q[31:26];
    assign bus.Rs        = inst_q[25:21];
    assign bus.Rt        = inst_q[20:16];
    assign bus.Rd        = inst_q[15:11];
    assign bus.Shamt     = inst_q[10:6];
    assign bus.Func      = inst_q[5:0];
    assign bus.Imm16     = inst_q[15:0];
    assign bus.Se        = flags_q.se;
    assign bus.ImmSel    = flags_q.imm_sel;
    assign bus.ShiftSel  = flags_q.shift_sel;
    assign bus.Illegal   = flags_q.illegal;

endmodule

// File: tb/tb_ir_decode_stage.sv
// Self-checking bench for ir_decode_stage: directed scenarios, a decode vector
// table and a randomized run against a behavioural pipeline/decode model.
module tb_ir_decode_stage;

    logic Clk;
    logic Rst;
    ir_decode_stage_if bus ();

    ir_decode_stage dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] inst;
        logic [3:0]  flags;   // {Se, ImmSel, ShiftSel, Illegal}
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] dut_flags();
        return {28'd0, bus.Se, bus.ImmSel, bus.ShiftSel, bus.Illegal};
    endfunction

    function automatic logic [31:0] extended();
        return bus.Se ? {{16{bus.Imm16[15]}}, bus.Imm16} : {16'd0, bus.Imm16};
    endfunction

    // Reference decode straight from the instruction-class rules.
    function automatic logic [3:0] ref_flags(input logic [31:0] inst);
        logic [5:0] op;
        logic [5:0] fn;
        logic se, imm, sh, ill, known_op, known_fn;
        op = inst[31:26];
        fn = inst[5:0];
        se  = op inside {6'b001000, 6'b001001, 6'b001010, 6'b001011,
                         6'b100011, 6'b101011, 6'b000100, 6'b000101};
        imm = op inside {6'b001000, 6'b001001, 6'b001010, 6'b001011,
                         6'b001100, 6'b001101, 6'b001110, 6'b001111,
                         6'b100011, 6'b101011};
        sh  = (op == 6'd0) && (fn inside {6'b000000, 6'b000010, 6'b000011});
        known_op = se || imm || (op inside {6'b000000, 6'b000010, 6'b000011});
        known_fn = fn inside {6'b000000, 6'b000010, 6'b000011, 6'b001000,
                              6'b100000, 6'b100001, 6'b100010, 6'b100011,
                              6'b100100, 6'b100101, 6'b100110, 6'b100111,
                              6'b101010, 6'b101011};
        ill = !known_op || ((op == 6'd0) && !known_fn);
        return {se, imm, sh, ill};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [5:0] ops[8];
        ops = '{6'b000000, 6'b001000, 6'b001101, 6'b100011,
                6'b000100, 6'b000010, 6'b001111, 6'b101011};
        if ($urandom_range(0, 1) == 0)
            return $urandom;
        return {ops[$urandom_range(0, 7)], 26'($urandom)};
    endfunction

    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_pc;

    initial begin
        vecs = '{
            '{32'h01095020, 4'b0000}, '{32'h01095021, 4'b0000},
            '{32'h01095022, 4'b0000}, '{32'h01095027, 4'b0000},
            '{32'h0109502A, 4'b0000}, '{32'h0109502B, 4'b0000},
            '{32'h01200008, 4'b0000}, '{32'h00094102, 4'b0010},
            '{32'h00094103, 4'b0010}, '{32'h00000001, 4'b0001},
            '{32'h01090018, 4'b0001}, '{32'h24080005, 4'b1100},
            '{32'h29080005, 4'b1100}, '{32'h2D080005, 4'b1100},
            '{32'h31080005, 4'b0100}, '{32'h39080005, 4'b0100},
            '{32'h3C08FFFF, 4'b0100}, '{32'hAD280008, 4'b1100},
            '{32'h15090003, 4'b1000}, '{32'h08000010, 4'b0000},
            '{32'h0C000010, 4'b0000}, '{32'h40000000, 4'b0001},
            '{32'h20000000, 4'b1100}
        };

        Rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        Rst = 1'b0;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_inst", bus.out_inst, 32'd0);
        check("reset out_pc", bus.out_pc, 32'd0);
        check("reset flags", dut_flags(), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);

        // addi $t0,$t1,-1
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h2128FFFF;
        bus.in_pc     = 32'h0000_0100;
        step();
        check("addi out_valid", 32'(bus.out_valid), 32'd1);
        check("addi Rs", 32'(bus.Rs), 32'd9);
        check("addi Rt", 32'(bus.Rt), 32'd8);
        check("addi Imm16", 32'(bus.Imm16), 32'hFFFF);
        check("addi flags", dut_flags(), 32'b1100);
        check("addi out_pc", bus.out_pc, 32'h0000_0100);
        check("addi extend", extended(), 32'hFFFFFFFF);

        // ori $t0,$t1,0x8000
        bus.in_inst = 32'h35288000;
        step();
        check("ori flags", dut_flags(), 32'b0100);
        check("ori extend", extended(), 32'h00008000);

        // sll $t0,$t1,4
        bus.in_inst = 32'h00094100;
        step();
        check("sll flags", dut_flags(), 32'b0010);
        check("sll Shamt", 32'(bus.Shamt), 32'd4);
        check("sll Rd", 32'(bus.Rd), 32'd8);

        // Back-pressure: lw held while sw waits at the input.
        bus.in_inst = 32'h8D280004;
        step();
        bus.out_ready = 1'b0;
        bus.in_inst   = 32'hAD280008;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp in_ready", 32'(bus.in_ready), 32'd0);
            step();
            check("bp out_valid", 32'(bus.out_valid), 32'd1);
            check("bp out_inst", bus.out_inst, 32'h8D280004);
            check("bp Imm16", 32'(bus.Imm16), 32'h0004);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("bp sw out_valid", 32'(bus.out_valid), 32'd1);
        check("bp sw out_inst", bus.out_inst, 32'hAD280008);
        step();
        check("bp no duplicate", 32'(bus.out_valid), 32'd0);

        // Flush discards an incoming beq.
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h10000003;
        bus.flush    = 1'b1;
        #1;
        check("flush in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check("flush out_valid", 32'(bus.out_valid), 32'd0);
        step();
        check("flush beq absent", 32'(bus.out_valid), 32'd0);

        // Flush drops a held instruction even under back-pressure.
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h01095020;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush held out_valid", 32'(bus.out_valid), 32'd0);

        // Decode table, one instruction per cycle.
        bus.out_ready = 1'b1;
        foreach (vecs[i]) begin
            bus.in_valid = 1'b1;
            bus.in_inst  = vecs[i].inst;
            bus.in_pc    = 32'h1000 + 32'(i) * 4;
            step();
            check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("vec%0d out_inst", i), bus.out_inst, vecs[i].inst);
            check($sformatf("vec%0d flags", i), dut_flags(), 32'(vecs[i].flags));
        end
        bus.in_valid = 1'b0;
        step();

        // Illegal opcode, then reset while it is held.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'hFC000000;
        step();
        check("illegal flag", dut_flags(), 32'b0001);
        check("illegal out_valid", 32'(bus.out_valid), 32'd1);
        Rst = 1'b1;
        bus.in_inst = 32'h2128FFFF;
        step();
        Rst = 1'b0;
        bus.in_valid = 1'b0;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst Illegal", 32'(bus.Illegal), 32'd0);
        check("rst out_inst", bus.out_inst, 32'd0);

        // Randomized run against the reference model.
        m_valid = 1'b0;
        m_inst  = '0;
        m_pc    = '0;
        for (int c = 0; c < 2000; c++) begin
            logic exp_ready;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
            bus.in_inst   = rand_inst();
            bus.in_pc     = $urandom;
            exp_ready = !m_valid || bus.out_ready || bus.flush;
            #1;
            check($sformatf("rnd%0d in_ready", c), 32'(bus.in_ready), 32'(exp_ready));
            if (bus.flush) begin
                m_valid = 1'b0;
            end else if (bus.in_valid && exp_ready) begin
                m_valid = 1'b1;
                m_inst  = bus.in_inst;
                m_pc    = bus.in_pc;
            end else if (m_valid && bus.out_ready) begin
                m_valid = 1'b0;
            end
            step();
            check($sformatf("rnd%0d out_valid", c), 32'(bus.out_valid), 32'(m_valid));
            if (m_valid) begin
                check($sformatf("rnd%0d out_inst", c), bus.out_inst, m_inst);
                check($sformatf("rnd%0d out_pc", c), bus.out_pc, m_pc);
                check($sformatf("rnd%0d flags", c), dut_flags(), 32'(ref_flags(m_inst)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ir_decode_stage.md
# ir_decode_stage

Instruction-register and field-decode stage between instruction fetch and the operand/extension logic of the MIPS32 datapath. It accepts one fetched instruction per handshake and holds it in a one-entry pipeline register. From the registered instruction it drives the register-number fields, the 16-bit immediate and its sign-extend select `Se`, and the 5-bit shift amount. These feed the 16-to-32 immediate extender and the 5-to-32 shift-amount extender directly. Downstream back-pressure and pipeline flush are supported.

## Interface
- No parameters; all widths fixed by MIPS32.
- `Clk` input 1: single clock; all state updates on rising edge.
- `Rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: fetch presents an instruction.
- `in_ready` output 1: stage can accept this cycle.
- `in_inst` input 32: instruction word.
- `in_pc` input 32: PC of `in_inst`.
- `flush` input 1: discard held and incoming instruction.
- `out_valid` output 1: registered instruction valid.
- `out_ready` input 1: downstream consumes this cycle.
- `out_inst`, `out_pc` output 32: held instruction and its PC.
- `Op` output 6 = inst[31:26]; `Func` output 6 = inst[5:0].
- `Rs`, `Rt`, `Rd` output 5 = inst[25:21], [20:16], [15:11].
- `Imm16` output 16 = inst[15:0], goes to extender `X`.
- `Shamt` output 5 = inst[10:6], goes to shift-amount extender.
- `Se` output 1: 1 = sign-extend `Imm16`, 0 = zero-extend.
- `ImmSel` output 1: ALU B operand is the extended immediate.
- `ShiftSel` output 1: ALU A operand is the extended `Shamt`.
- `Illegal` output 1: opcode/funct not supported.

## Operation
- Handshake:
  - `in_ready = !out_valid || out_ready || flush` (combinational).
  - A transfer occurs when `in_valid && in_ready`.
- Register update, in priority order:
  1. `Rst`: all outputs cleared.
  2. `flush`: `out_valid` <= 0. Any incoming transfer in the same cycle is consumed and discarded.
  3. Transfer: load `in_inst`/`in_pc` and the decoded flags; `out_valid` <= 1.
  4. `out_valid && out_ready` with no transfer: `out_valid` <= 0. Data registers hold.
  5. Otherwise: hold everything.
- Decode is performed on `in_inst` and registered together with it. All decoded outputs are therefore flop outputs.
- `Se` = 1 for opcodes:
  - 001000 addi, 001001 addiu, 001010 slti, 001011 sltiu
  - 100011 lw, 101011 sw, 000100 beq, 000101 bne
- `Se` = 0 for 001100 andi, 001101 ori, 001110 xori, 001111 lui, R-type and jumps.
- `ImmSel` = 1 for addi/addiu/slti/sltiu/andi/ori/xori/lui/lw/sw. It is 0 for beq/bne, R-type and j/jal.
- `ShiftSel` = 1 only for Op = 000000 with Func in {000000 sll, 000010 srl, 000011 sra}.
- `Illegal` = 1 when Op is none of the above and not 000010 j / 000011 jal.
- R-type Func values outside {sll, srl, sra, 100000 add, 100001 addu, 100010 sub, 100011 subu, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 101011 sltu, 001000 jr} also set `Illegal`.
- An illegal instruction still passes through normally. Only the flag marks it.
- Flags are meaningful only while `out_valid` = 1.

## Timing
- Reset values:
  - `out_valid` = 0.
  - `out_inst` = 0 and `out_pc` = 0; the zero word is an sll nop.
  - All field outputs = 0.
  - `Se` = 0, `ImmSel` = 0, `ShiftSel` = 0, `Illegal` = 0.
  - `in_ready` = 1 after reset.
- Latency: 1 cycle, transfer edge to `out_valid`/fields.
- Throughput: 1 instruction/cycle while `out_ready` = 1.
- Back-pressure (`out_valid` = 1, `out_ready` = 0):
  - `in_ready` = 0.
  - All outputs stable until consumed.
  - `in_inst` is not sampled.
- Simultaneous consume and transfer: the new instruction replaces the old with `out_valid` staying 1. No bubble is inserted.
- `flush` together with `out_ready` = 0: held instruction is dropped anyway. Next cycle `out_valid` = 0.
- `Rst` mid-stream: the held instruction is lost. `in_valid` in the reset cycle is ignored.

## Test plan
- Reset, then `in_inst` = 0x2128FFFF (addi $t0,$t1,-1), `out_ready` = 1.
  - Next cycle: `out_valid` = 1, `Rs` = 9, `Rt` = 8, `Imm16` = 0xFFFF, `Se` = 1, `ImmSel` = 1, `Illegal` = 0.
  - Extender output 0xFFFFFFFF.
- `in_inst` = 0x35288000 (ori $t0,$t1,0x8000).
  - Required: `Se` = 0, `ImmSel` = 1.
  - Extender output 0x00008000.
- `in_inst` = 0x00094100 (sll $t0,$t1,4).
  - Required: `ShiftSel` = 1, `Shamt` = 4, `Rd` = 8, `Se` = 0, `ImmSel` = 0.
- Back-pressure:
  - Load 0x8D280004 (lw) with `out_ready` = 0 for 3 cycles while fetch presents 0xAD280008 (sw).
  - Required during those 3 cycles: `in_ready` = 0, and outputs stay at lw with `Imm16` = 0x0004.
  - Raise `out_ready`: sw appears the next cycle with no gap and no duplicate.
- `flush` in the same cycle as `in_valid` with 0x10000003 (beq).
  - Required next cycle: `out_valid` = 0.
  - The beq never appears, and `in_ready` = 1 during the flush.
- `in_inst` = 0xFC000000, then assert `Rst` while it is held.
  - First: `Illegal` = 1 with `out_valid` = 1.
  - After the `Rst` edge: `out_valid` = 0 and `Illegal` = 0.
